unpacked_array_arbiter: RTL and testbench
=========================================

# unpacked_array_arbiter

Owns an unpacked register array (`o_x[DEPTH-1:0]`) and shares its write access between two requesters using round-robin arbitration. It also runs a sequenced broadcast-fill operation that replicates one value into every entry, one entry per cycle. It is the write-side controller feeding unpacked-array consumers, such as interface-held arrays and top-level unpacked outputs.

## Interface
- `DEPTH`, 8, number of array entries; must be a power of two and ≥2
- `WIDTH`, 8, bits per entry
- `AW`, `$clog2(DEPTH)`, address width (derived, not overridden)

Ports:
- `i_clk`  input  1  sole clock, rising edge
- `i_rst_n`  input  1  reset, asynchronous assert, active-low
- `i_req_0`, `i_req_1`  input  1  write request, per requester
- `i_addr_0`, `i_addr_1`  input  AW  target entry, per requester
- `i_data_0`, `i_data_1`  input  WIDTH  write data, per requester
- `o_gnt_0`, `o_gnt_1`  output  1  grant, combinational, one-hot or zero
- `i_fill`  input  1  start broadcast fill
- `i_fill_data`  input  WIDTH  fill value, sampled with `i_fill`
- `o_busy`  output  1  fill in progress
- `o_done`  output  1  one-cycle pulse after fill completes
- `o_x`  output  WIDTH, unpacked [DEPTH-1:0]  array contents, registered

## Operation
- States: IDLE, FILL. Reset state is IDLE.
- Reset values:
  - every `o_x` entry is 0
  - `o_busy`=0, `o_done`=0, `o_gnt_*`=0
  - round-robin pointer favours requester 0
  - fill counter is 0
- IDLE, `i_fill`=1:
  - latch `i_fill_data`, clear the counter, go to FILL
  - `o_gnt_*` stay 0 in that cycle, because fill has priority over requests
- IDLE, `i_fill`=0: arbitrate requests.
  - Only one requester active: grant it.
  - Both active: grant the requester not granted most recently.
  - The granted write of its data to its address lands at the next edge.
  - The pointer updates only on a cycle with a grant.
  - Ungranted requesters simply hold their request; there is no queueing inside the block.
- FILL:
  - write the latched value to entry[cnt] each cycle, then cnt++
  - after entry DEPTH-1 is written, return to IDLE and pulse `o_done`
  - all grants are 0; `i_fill` is ignored
  - `i_fill_data` changes after the start cycle have no effect
- `o_busy` = (state == FILL).
- Address arithmetic: the counter is AW+1 bits, and the terminal test is cnt == DEPTH-1. Requester addresses are AW bits and cannot go out of range.
- Asynchronous reset mid-fill aborts the fill immediately. The array clears, and no `o_done` is issued.

## Timing
- Grant is combinational in the request cycle. The written entry is visible on `o_x` one cycle later (latency 1).
- Fill sampled at edge T:
  - entry k written at edge T+1+k
  - `o_busy` high from edge T to edge T+DEPTH (DEPTH cycles)
  - `o_done` high for exactly the cycle following edge T+DEPTH
  - arbitration resumes in that same cycle
- Back-to-back fills: `i_fill` in the `o_done` cycle starts a new fill. The minimum period is DEPTH+1 cycles.
- Unrequested entries hold their value indefinitely.

## Test plan
- Reset: drive `i_rst_n`=0 mid-operation → all 8 `o_x` entries 0, `o_busy`=`o_done`=`o_gnt_*`=0, asynchronously before the next clock edge.
- Single write: `i_req_0`=1, `i_addr_0`=3, `i_data_0`=0xA5 → `o_gnt_0`=1 in the same cycle, `o_x[3]`=0xA5 one cycle later, all other entries unchanged.
- Contention: both requests held for 4 cycles (req0 addr1 data 0x11, req1 addr2 data 0x22) → grants alternate 0,1,0,1, and `o_x[1]`=0x11, `o_x[2]`=0x22.
- Fill: `i_fill`=1 with data 0x3C, and `i_req_1` held high throughout →
  - `o_busy` high for 8 cycles, `o_gnt_1` stays 0
  - entry k becomes 0x3C at edge T+1+k
  - `o_done` pulses once
  - `o_gnt_1`=1 in the `o_done` cycle
- Fill vs request in the same cycle: `i_fill` and `i_req_0` both asserted → `o_gnt_0`=0, fill starts, request granted only after fill completes.
- Reset mid-fill: assert reset after 4 entries are written → array all 0, state IDLE, no `o_done`; a new fill then completes normally.

Source files
------------

// File: rtl/unpacked_array_arbiter.sv
// Write-side controller for an unpacked register array: round-robin arbitration
// between two requesters plus a sequenced broadcast fill, one entry per cycle.
module unpacked_array_arbiter #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_0,
    input  logic             i_req_1,
    input  logic [AW-1:0]    i_addr_0,
    input  logic [AW-1:0]    i_addr_1,
    input  logic [WIDTH-1:0] i_data_0,
    input  logic [WIDTH-1:0] i_data_1,
    output logic             o_gnt_0,
    output logic             o_gnt_1,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_fill_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_x [DEPTH-1:0]
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t           state;
    state_t           state_next;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] fill_val;
    logic             ptr;          // 1: requester 1 wins the next tie
    logic             gnt_0;
    logic             gnt_1;
    logic             fill_start;
    logic             fill_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are gated by reset so they drop asynchronously with it.
    always_comb begin
        state_next = state;
        gnt_0      = 1'b0;
        gnt_1      = 1'b0;
        fill_start = 1'b0;
        fill_last  = 1'b0;
        case (state)
            IDLE: begin
                if (i_fill) begin
                    fill_start = 1'b1;
                    state_next = FILL;
                end else if (i_rst_n) begin
                    if (i_req_0 && (!i_req_1 || !ptr)) begin
                        gnt_0 = 1'b1;
                    end else if (i_req_1) begin
                        gnt_1 = 1'b1;
                    end
                end
            end
            FILL: begin
                if (cnt == CNT_LAST) begin
                    fill_last  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            fill_val <= '0;
            ptr      <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= fill_last;
            if (fill_start) begin
                cnt      <= '0;
                fill_val <= i_fill_data;
            end else if (state == FILL) begin
                cnt <= cnt + CNT_ONE;
            end
            if (gnt_0) begin
                ptr <= 1'b1;
            end else if (gnt_1) begin
                ptr <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                o_x[i] <= '0;
            end
        end else if (state == FILL) begin
            o_x[cnt[AW-1:0]] <= fill_val;
        end else if (gnt_0) begin
            o_x[i_addr_0] <= i_data_0;
        end else if (gnt_1) begin
            o_x[i_addr_1] <= i_data_1;
        end
    end

    assign o_gnt_0 = gnt_0;
    assign o_gnt_1 = gnt_1;
    assign o_busy  = (state == FILL);

endmodule

// File: tb/tb_unpacked_array_arbiter.sv
// Self-checking bench for unpacked_array_arbiter: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_unpacked_array_arbiter;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0, fill = 1'b0;
    logic [AW-1:0]    a0 = '0, a1 = '0;
    logic [WIDTH-1:0] d0 = '0, d1 = '0, fd = '0;
    logic             g0, g1, busy, done;
    logic [WIDTH-1:0] x [DEPTH-1:0];

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: array image, fill position (-1 when idle), last grant.
    logic [WIDTH-1:0] mx [DEPTH-1:0];
    int               fill_pos;
    logic [WIDTH-1:0] fill_val;
    logic             exp_done;
    int               last_gnt;

    unpacked_array_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_0(req0), .i_req_1(req1),
        .i_addr_0(a0), .i_addr_1(a1),
        .i_data_0(d0), .i_data_1(d1),
        .o_gnt_0(g0), .o_gnt_1(g1),
        .i_fill(fill), .i_fill_data(fd),
        .o_busy(busy), .o_done(done),
        .o_x(x)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_gnt();
        if (!rst_n || fill_pos >= 0 || fill) return 2'b00;
        if (req0 && req1) return (last_gnt == 1) ? 2'b01 : 2'b10;
        return {req1, req0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mx[i] = '0;
        fill_pos = -1;
        fill_val = '0;
        exp_done = 1'b0;
        last_gnt = 1;
    endtask

    // Advance model and DUT by one clock; returns 1 time unit after the edge.
    task automatic cycle();
        logic [1:0] g;
        g = exp_gnt();
        if (rst_n) begin
            exp_done = 1'b0;
            if (fill_pos >= 0) begin
                mx[fill_pos] = fill_val;
                if (fill_pos == DEPTH - 1) begin
                    fill_pos = -1;
                    exp_done = 1'b1;
                end else begin
                    fill_pos++;
                end
            end else if (fill) begin
                fill_pos = 0;
                fill_val = fd;
            end else if (g[0]) begin
                mx[a0] = d0;
                last_gnt = 0;
            end else if (g[1]) begin
                mx[a1] = d1;
                last_gnt = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req0 = 1'b1; a0 = 3'd5; d0 = 8'h77;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_x[%0d] got %h exp 00", i, x[i]);
            end
        end
        n_cmp++;
        if ({busy, done, g0, g1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy/done/g0/g1=%b exp 0000", {busy, done, g0, g1});
        end
        model_reset();
        req0 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_contention();
        req0 = 1'b1; a0 = 3'd1; d0 = 8'h11;
        req1 = 1'b1; a1 = 3'd2; d1 = 8'h22;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_cmp++;
            if ({g1, g0} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL contention_gnt[%0d] got g1g0=%b exp %b", c, {g1, g0},
                         (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
        #2;
        n_cmp++;
        if (x[1] !== 8'h11 || x[2] !== 8'h22) begin
            n_fail++;
            $display("FAIL contention_data got x1=%h x2=%h exp 11 22", x[1], x[2]);
        end
    endtask

    task automatic test_single_write();
        req0 = 1'b1; a0 = 3'd3; d0 = 8'hA5;
        #2;
        n_cmp++;
        if ({g1, g0} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_gnt got g1g0=%b exp 01", {g1, g0});
        end
        cycle();
        req0 = 1'b0;
        #2;
        n_cmp++;
        if (x[3] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_x3 got %h exp a5", x[3]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== mx[i]) begin
                n_fail++;
                $display("FAIL single_x[%0d] got %h exp %h", i, x[i], mx[i]);
            end
        end
    endtask

    task automatic test_fill();
        fill = 1'b1; fd = 8'h3C;
        req1 = 1'b1; a1 = 3'd6; d1 = 8'h99;
        #2;
        n_cmp++;
        if ({g1, g0, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL fill_start got g1/g0/busy=%b exp 000", {g1, g0, busy});
        end
        cycle();
        fill = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            fd = 8'($urandom);
            #2;
            n_cmp++;
            if ({busy, done, g1} !== 3'b100) begin
                n_fail++;
                $display("FAIL fill_ctrl[%0d] got busy/done/g1=%b exp 100", j, {busy, done, g1});
            end
            if (j >= 1) begin
                n_cmp++;
                if (x[j-1] !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL fill_entry[%0d] got %h exp 3c", j - 1, x[j-1]);
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_cmp++;
                if (x[i] !== mx[i]) begin
                    n_fail++;
                    $display("FAIL fill_x[%0d] cyc %0d got %h exp %h", i, j, x[i], mx[i]);
                end
            end
            cycle();
        end
        #2;
        n_cmp++;
        if ({busy, done, g1} !== 3'b011) begin
            n_fail++;
            $display("FAIL fill_done got busy/done/g1=%b exp 011", {busy, done, g1});
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== 8'h3C) begin
                n_fail++;
                $display("FAIL fill_final[%0d] got %h exp 3c", i, x[i]);
            end
        end
        cycle();
        req1 = 1'b0;
        #2;
        n_cmp++;
        if (done !== 1'b0 || x[6] !== 8'h99) begin
            n_fail++;
            $display("FAIL fill_after got done=%b x6=%h exp 0 99", done, x[6]);
        end
    endtask

    task automatic test_fill_vs_request();
        fill = 1'b1; fd = 8'h5A;
        req0 = 1'b1; a0 = 3'd0; d0 = 8'hE7;
        #2;
        n_cmp++;
        if (g0 !== 1'b0) begin
            n_fail++;
            $display("FAIL fvr_gnt_start got %b exp 0", g0);
        end
        cycle();
        fill = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            #2;
            n_cmp++;
            if ({busy, g0} !== 2'b10) begin
                n_fail++;
                $display("FAIL fvr_busy[%0d] got busy/g0=%b exp 10", j, {busy, g0});
            end
            cycle();
        end
        #2;
        n_cmp++;
        if ({done, g0} !== 2'b11) begin
            n_fail++;
            $display("FAIL fvr_done got done/g0=%b exp 11", {done, g0});
        end
        cycle();
        req0 = 1'b0;
        #2;
        n_cmp++;
        if (x[0] !== 8'hE7 || x[1] !== 8'h5A) begin
            n_fail++;
            $display("FAIL fvr_data got x0=%h x1=%h exp e7 5a", x[0], x[1]);
        end
    endtask

    task automatic test_back_to_back();
        fill = 1'b1; fd = 8'hC3;
        cycle();
        fill = 1'b0;
        repeat (DEPTH) cycle();
        fill = 1'b1; fd = 8'h96;
        #2;
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_first_done got busy/done=%b exp 01", {busy, done});
        end
        cycle();
        fill = 1'b0;
        #2;
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_restart got busy/done=%b exp 10", {busy, done});
        end
        repeat (DEPTH) cycle();
        #2;
        n_cmp++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_second_done got busy/done=%b exp 01", {busy, done});
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== 8'h96) begin
                n_fail++;
                $display("FAIL b2b_x[%0d] got %h exp 96", i, x[i]);
            end
        end
        cycle();
    endtask

    task automatic test_reset_mid_fill();
        fill = 1'b1; fd = 8'h81;
        cycle();
        fill = 1'b0;
        repeat (4) cycle();
        n_cmp++;
        if (x[3] !== 8'h81 || x[4] !== mx[4]) begin
            n_fail++;
            $display("FAIL rmf_partial got x3=%h x4=%h exp 81 %h", x[3], x[4], mx[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL rmf_x[%0d] got %h exp 00", i, x[i]);
            end
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < DEPTH + 2; j++) begin
            #2;
            n_cmp++;
            if ({busy, done} !== 2'b00) begin
                n_fail++;
                $display("FAIL rmf_idle[%0d] got busy/done=%b exp 00", j, {busy, done});
            end
            cycle();
        end
        fill = 1'b1; fd = 8'h42;
        cycle();
        fill = 1'b0;
        repeat (DEPTH) cycle();
        #2;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rmf_refill_done got %b exp 1", done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (x[i] !== 8'h42) begin
                n_fail++;
                $display("FAIL rmf_refill_x[%0d] got %h exp 42", i, x[i]);
            end
        end
        cycle();
    endtask

    task automatic test_random();
        logic [1:0] eg;
        for (int c = 0; c < 400; c++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            a0 = 3'($urandom);   a1 = 3'($urandom);
            d0 = 8'($urandom);   d1 = 8'($urandom);
            fill = ($urandom_range(0, 11) == 0);
            fd = 8'($urandom);
            #2;
            eg = exp_gnt();
            n_cmp++;
            if ({g1, g0} !== eg || busy !== (fill_pos >= 0) || done !== exp_done) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d] got g1g0=%b busy=%b done=%b exp %b %b %b",
                         c, {g1, g0}, busy, done, eg, (fill_pos >= 0), exp_done);
            end
            for (int i = 0; i < DEPTH; i++) begin
                n_cmp++;
                if (x[i] !== mx[i]) begin
                    n_fail++;
                    $display("FAIL rand_x[%0d] cyc %0d got %h exp %h", i, c, x[i], mx[i]);
                end
            end
            cycle();
        end
        req0 = 1'b0; req1 = 1'b0; fill = 1'b0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_fill();
        test_fill_vs_request();
        test_back_to_back();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
